// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: host-side UART command sequencer.
// Sends an N-byte command MSB byte first, then collects a counted response.
module uart_cmd_seq #(
  parameter int          CMD_BYTES   = 3,
  parameter int          MAX_RESP    = 512,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ACK_VAL     = 8'hA5,
  parameter logic [7:0]  NAK_VAL     = 8'hEE,
  parameter int          RESP_W      = $clog2(MAX_RESP + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*CMD_BYTES-1:0] cmd,
  input  logic [RESP_W-1:0]      resp_len,
  input  logic                   send_cmd,
  input  logic                   abort,
  output logic [7:0]             tx_data,
  output logic                   trmt,
  input  logic                   tx_done,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy,
  output logic                   busy,
  output logic                   cmd_sent,
  output logic                   resp_vld,
  output logic [7:0]             resp_byte,
  output logic [RESP_W-1:0]      resp_idx,
  output logic                   done,
  output logic                   ack_ok,
  output logic                   nak,
  output logic                   timeout
);

  localparam int CW   = 8 * CMD_BYTES;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BC_W = 3;

  localparam logic [RESP_W-1:0] MAX_R   = RESP_W'(MAX_RESP);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BC_W-1:0]   LAST_B  = BC_W'(CMD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TXW,
    S_RXW,
    S_RXC,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     sr_q, sr_d;
  logic [RESP_W-1:0] len_q, len_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [RESP_W-1:0] rcnt_q, rcnt_d;
  logic [TO_W-1:0]   tocnt_q, tocnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              trmt_q, trmt_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              sent_q, sent_d;
  logic              vld_q, vld_d;
  logic [7:0]        rbyte_q, rbyte_d;
  logic [RESP_W-1:0] ridx_q, ridx_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              nak_q, nak_d;
  logic              to_q, to_d;
  logic              abort_hit;

  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    len_d     = len_q;
    bcnt_d    = bcnt_q;
    rcnt_d    = rcnt_q;
    tocnt_d   = '0;
    tx_data_d = tx_data_q;
    trmt_d    = 1'b0;
    clr_d     = 1'b0;
    busy_d    = busy_q;
    sent_d    = 1'b0;
    vld_d     = 1'b0;
    rbyte_d   = rbyte_q;
    ridx_d    = ridx_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    nak_d     = nak_q;
    to_d      = to_q;
    // abort beats every other transition and suppresses strobes
    if (abort_hit) begin
      state_d = S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (send_cmd) begin
            sr_d    = cmd;
            len_d   = (resp_len > MAX_R) ? MAX_R : resp_len;
            bcnt_d  = '0;
            rcnt_d  = '0;
            ack_d   = 1'b0;
            nak_d   = 1'b0;
            to_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data_d = sr_q[CW-1 -: 8];
          trmt_d    = 1'b1;
          state_d   = S_TXW;
        end
        S_TXW: begin
          if (tx_done) begin
            sr_d   = sr_q << 8;
            bcnt_d = bcnt_q + BC_W'(1);
            if (bcnt_q != LAST_B) begin
              state_d = S_LOAD;
            end else begin
              sent_d  = 1'b1;
              state_d = (len_q != '0) ? S_RXW : S_DONE;
            end
          end
        end
        S_RXW: begin
          if (rx_rdy) begin
            rbyte_d = rx_data;
            ridx_d  = rcnt_q;
            vld_d   = 1'b1;
            clr_d   = 1'b1;
            rcnt_d  = rcnt_q + RESP_W'(1);
            if (rcnt_q == '0) begin
              nak_d = (rx_data == NAK_VAL);
              ack_d = (len_q == RESP_W'(1)) && (rx_data == ACK_VAL);
            end
            state_d = S_RXC;
          end else if (tocnt_q == TO_LAST) begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            tocnt_d = tocnt_q + TO_W'(1);
          end
        end
        S_RXC: begin
          state_d = (rcnt_q == len_q) ? S_DONE : S_RXW;
        end
        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      len_q     <= '0;
      bcnt_q    <= '0;
      rcnt_q    <= '0;
      tocnt_q   <= '0;
      tx_data_q <= '0;
      trmt_q    <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      vld_q     <= 1'b0;
      rbyte_q   <= '0;
      ridx_q    <= '0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      len_q     <= len_d;
      bcnt_q    <= bcnt_d;
      rcnt_q    <= rcnt_d;
      tocnt_q   <= tocnt_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      vld_q     <= vld_d;
      rbyte_q   <= rbyte_d;
      ridx_q    <= ridx_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      nak_q     <= nak_d;
      to_q      <= to_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign clr_rx_rdy = clr_q;
  assign busy       = busy_q;
  assign cmd_sent   = sent_q;
  assign resp_vld   = vld_q;
  assign resp_byte  = rbyte_q;
  assign resp_idx   = ridx_q;
  assign done       = done_q;
  assign ack_ok     = ack_q;
  assign nak        = nak_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: directed bench for uart_cmd_seq.
// A small transceiver model answers trmt and serves response bytes.
module tb_uart_cmd_seq;

  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   cmd = '0;
  logic [RW-1:0] resp_len = '0;
  logic          send_cmd = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    tx_data;
  logic          trmt;
  logic          tx_done = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_rdy = 1'b0;
  logic          clr_rx_rdy;
  logic          busy;
  logic          cmd_sent;
  logic          resp_vld;
  logic [7:0]    resp_byte;
  logic [RW-1:0] resp_idx;
  logic          done;
  logic          ack_ok;
  logic          nak;
  logic          timeout;

  uart_cmd_seq #(
    .CMD_BYTES  (3),
    .MAX_RESP   (512),
    .TIMEOUT_CYC(100),
    .ACK_VAL    (8'hA5),
    .NAK_VAL    (8'hEE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .resp_len  (resp_len),
    .send_cmd  (send_cmd),
    .abort     (abort),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .tx_done   (tx_done),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_rx_rdy),
    .busy      (busy),
    .cmd_sent  (cmd_sent),
    .resp_vld  (resp_vld),
    .resp_byte (resp_byte),
    .resp_idx  (resp_idx),
    .done      (done),
    .ack_ok    (ack_ok),
    .nak       (nak),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] outs();
    return {29'b0, tx_data, trmt, clr_rx_rdy, busy, cmd_sent, resp_vld,
            resp_byte, resp_idx, done, ack_ok, nak, timeout};
  endfunction

  // receive configuration, written only by the stimulus block
  int         cfg_seq = 0;
  int         cfg_n   = 0;
  bit         cfg_inc = 1'b0;
  logic [7:0] cfg_fix = '0;

  // transceiver model
  int seen_seq  = 0;
  int tx_wait_n = 0;
  int rx_left   = 0;
  int rx_gap    = 0;
  int rx_i      = 0;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_wait_n = 0;
    end else begin
      if (tx_wait_n > 0) begin
        tx_wait_n--;
        if (tx_wait_n == 0) tx_done = 1'b1;
      end
      if (trmt === 1'b1) tx_wait_n = 3;
    end
    if (cfg_seq != seen_seq) begin
      seen_seq = cfg_seq;
      rx_rdy   = 1'b0;
      rx_left  = cfg_n;
      rx_i     = 0;
      rx_gap   = 2;
    end else if (clr_rx_rdy === 1'b1) begin
      rx_rdy = 1'b0;
      rx_gap = 2;
    end else if (!rx_rdy && rx_left > 0) begin
      if (rx_gap > 0) begin
        rx_gap--;
      end else begin
        rx_data = cfg_inc ? rx_i[7:0] : cfg_fix;
        rx_rdy  = 1'b1;
        rx_i++;
        rx_left--;
      end
    end
  end

  // event monitor
  int          cyc = 0;
  int          mon_seq = 0;
  int          mon_seen = 0;
  int          trmt_cnt, clr_cnt, vld_cnt, sent_cnt, idx_err;
  int          vld_cyc, to_cyc;
  logic [31:0] tx_pack;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_seq != mon_seen) begin
      mon_seen = mon_seq;
      trmt_cnt = 0;
      clr_cnt  = 0;
      vld_cnt  = 0;
      sent_cnt = 0;
      idx_err  = 0;
      vld_cyc  = 0;
      to_cyc   = 0;
      tx_pack  = '0;
    end
    if (trmt === 1'b1) begin
      trmt_cnt++;
      tx_pack = {tx_pack[23:0], tx_data};
    end
    if (clr_rx_rdy === 1'b1) clr_cnt++;
    if (cmd_sent === 1'b1) sent_cnt++;
    if (resp_vld === 1'b1) begin
      if (resp_idx !== RW'(vld_cnt) ||
          resp_byte !== (cfg_inc ? vld_cnt[7:0] : cfg_fix))
        idx_err++;
      vld_cnt++;
      vld_cyc = cyc;
    end
    if (timeout === 1'b1 && to_cyc == 0) to_cyc = cyc;
  end

  task automatic clear_mon();
    mon_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic rx_setup(input bit inc, input logic [7:0] fix,
                          input int n);
    cfg_inc = inc;
    cfg_fix = fix;
    cfg_n   = n;
    cfg_seq++;
  endtask

  task automatic start(input logic [23:0] c, input logic [RW-1:0] l);
    @(negedge clk);
    cmd      = c;
    resp_len = l;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    int n;
    int clr0, trmt0;

    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;

    // ack write
    clear_mon();
    rx_setup(1'b0, 8'hA5, 1);
    start(24'h08_2A_BB, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1_done", 300);
    chk("t1_ack", ack_ok, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_nak", nak, 0);
    chk("t1_tx_bytes", tx_pack, 32'h0008_2ABB);
    chk("t1_trmt_cnt", trmt_cnt, 3);
    chk("t1_sent_cnt", sent_cnt, 1);
    chk("t1_vld_cnt", vld_cnt, 1);
    chk("t1_clr_cnt", clr_cnt, 1);
    chk("t1_byte", resp_byte, 8'hA5);
    chk("t1_idx", resp_idx, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_ack_sticky", ack_ok, 1);

    // channel dump
    clear_mon();
    rx_setup(1'b1, 8'h00, 510);
    start(24'h01_00_FF, 510);
    wait_done("t2_done", 10000);
    chk("t2_vld_cnt", vld_cnt, 510);
    chk("t2_clr_cnt", clr_cnt, 510);
    chk("t2_idx_err", idx_err, 0);
    chk("t2_last_idx", resp_idx, 509);
    chk("t2_last_byte", resp_byte, 8'hFD);
    chk("t2_ack", ack_ok, 0);
    chk("t2_tx_bytes", tx_pack, 32'h0001_00FF);

    // nak
    clear_mon();
    rx_setup(1'b0, 8'hEE, 1);
    start(24'h0A_0B_0C, 1);
    wait_done("t3_done", 300);
    chk("t3_nak", nak, 1);
    chk("t3_ack", ack_ok, 0);
    chk("t3_vld_cnt", vld_cnt, 1);
    chk("t3_byte", resp_byte, 8'hEE);

    // timeout after one of two bytes
    clear_mon();
    rx_setup(1'b0, 8'h5A, 1);
    start(24'h12_34_56, 2);
    chk("t4_nak_cleared", nak, 0);
    wait_done("t4_done", 400);
    chk("t4_timeout", timeout, 1);
    chk("t4_vld_cnt", vld_cnt, 1);
    chk("t4_to_latency", to_cyc - vld_cyc, 101);
    chk("t4_busy_low", busy, 0);

    // ignored send_cmd, then abort in second byte's TX_WAIT
    clear_mon();
    rx_setup(1'b0, 8'h00, 0);
    start(24'h11_22_33, 1);
    chk("t5_to_cleared", timeout, 0);
    cmd      = 24'h44_55_66;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    n = 0;
    while (trmt_cnt < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_trmt2", trmt_cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_busy_low", busy, 0);
    repeat (20) @(negedge clk);
    chk("t5_trmt_cnt", trmt_cnt, 2);
    chk("t5_sent_cnt", sent_cnt, 0);
    chk("t5_tx_bytes", tx_pack, 32'h0000_1122);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_idle_abort", {busy, done}, 0);
    @(negedge clk);
    chk("t5_idle_abort2", {busy, done}, 0);

    // async reset mid-dump
    clear_mon();
    rx_setup(1'b1, 8'h00, 510);
    start(24'h01_00_FF, 510);
    n = 0;
    while (vld_cnt < 101 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_reached", vld_cnt, 101);
    chk("t6_idx100", resp_idx, 100);
    clr0  = clr_cnt;
    trmt0 = trmt_cnt;
    rx_setup(1'b0, 8'h00, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", outs(), 0);
    repeat (3) @(negedge clk);
    chk("t6_held_outs", outs(), 0);
    chk("t6_no_clr", clr_cnt, clr0);
    chk("t6_no_trmt", trmt_cnt, trmt0);
    rst_n = 1'b1;
    clear_mon();
    rx_setup(1'b0, 8'hA5, 1);
    start(24'hC0_FF_EE, 1);
    wait_done("t6_done", 300);
    chk("t6_ack", ack_ok, 1);
    chk("t6_tx_bytes", tx_pack, 32'h00C0_FFEE);
    chk("t6_vld_cnt", vld_cnt, 1);

    // resp_len above MAX_RESP is clamped
    clear_mon();
    rx_setup(1'b1, 8'h00, 1023);
    start(24'h01_02_03, 1023);
    wait_done("t7_done", 12000);
    chk("t7_vld_cnt", vld_cnt, 512);
    chk("t7_last_idx", resp_idx, 511);
    chk("t7_idx_err", idx_err, 0);
    rx_setup(1'b0, 8'h00, 0);

    // zero-length response
    clear_mon();
    start(24'hAA_BB_CC, 0);
    wait_done("t8_done", 300);
    chk("t8_sent_cnt", sent_cnt, 1);
    chk("t8_vld_cnt", vld_cnt, 0);
    chk("t8_tx_bytes", tx_pack, 32'h00AA_BBCC);
    chk("t8_timeout", timeout, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
